// File: rtl/core_pkg.sv
// Shared definitions for the instruction-memory server and its RAM.
package core_pkg;

    localparam int INST_W       = 32;
    localparam int ADDR_W_DEF   = 14;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT,
        EXEC
    } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-port write-first instruction RAM with registered read data.
import core_pkg::*;

module imem_ram #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [INST_W-1:0] wdata,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/imem_server.sv
// Instruction-memory responder: owns the PC, serves words to fetch.
import core_pkg::*;

module imem_server #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DEPTH    = 2**ADDR_W,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              fetch_finish,
    input  logic              retire,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [31:0]       odata,
    output logic              f_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              proto_err
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    imem_state_t       state;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [INST_W-1:0] ram_rdata;
    logic              viol;

    // Loader owns the port only in IDLE; otherwise it always reads pc.
    assign ram_we   = prog_we && (state == IDLE);
    assign ram_addr = ram_we ? prog_addr : pc;

    assign viol = (fetch_finish && (state != WAIT))
               || ((retire || jump_en) && (state != EXEC))
               || (prog_we && (state != IDLE));

    imem_ram #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(prog_data),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RST_PC;
            odata     <= '0;
            f_valid   <= 1'b0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            f_valid <= 1'b0;
            if (viol) begin
                proto_err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start && !prog_we) begin
                        state <= ADDR;
                        busy  <= 1'b1;
                    end
                end
                ADDR: begin
                    state <= DATA;
                end
                DATA: begin
                    odata   <= ram_rdata;
                    f_valid <= 1'b1;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (fetch_finish) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (jump_en || retire) begin
                        pc    <= jump_en ? jump_addr : pc + PC_ONE;
                        state <= halt ? IDLE : ADDR;
                        busy  <= !halt;
                    end else if (halt) begin
                        pc    <= RST_PC;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_server.sv
// Directed bench for imem_server with hand-computed expectations.
module tb_imem_server;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        prog_we = 1'b0;
    logic [13:0] prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        fetch_finish = 1'b0;
    logic        retire = 1'b0;
    logic        jump_en = 1'b0;
    logic [13:0] jump_addr = '0;
    logic [31:0] odata;
    logic        f_valid;
    logic [13:0] pc;
    logic        busy;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    imem_server dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt        (halt),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .fetch_finish(fetch_finish),
        .retire      (retire),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .odata       (odata),
        .f_valid     (f_valid),
        .pc          (pc),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [13:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic step(input logic ret, input logic jmp,
                        input logic [13:0] ja, input logic hlt);
        retire    = ret;
        jump_en   = jmp;
        jump_addr = ja;
        halt      = hlt;
        tick();
        retire  = 1'b0;
        jump_en = 1'b0;
        halt    = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ack();
        tick();
        fetch_finish = 1'b1;
        tick();
        fetch_finish = 1'b0;
    endtask

    // Called right after the triggering edge; expects f_valid two edges later.
    task automatic fetch(input string tag, input logic [13:0] epc,
                         input logic [31:0] edat);
        int lat;
        lat = 0;
        while (!f_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_odata"}, odata, edat);
        chk({tag, "_pc"}, {18'd0, pc}, {18'd0, epc});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, {18'd0, pc}, 32'd0);
        chk({tag, "_odata"}, odata, 32'd0);
        chk({tag, "_fv"}, {31'd0, f_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_perr"}, {31'd0, proto_err}, 32'd0);
    endtask

    initial begin
        int nfv;
        rst = 1'b1;
        #1;
        chk_reset("rst0");
        tick();
        rst = 1'b0;

        load(14'd0, 32'h11111111);
        load(14'd1, 32'h22222222);
        load(14'd2, 32'h33333333);
        load(14'h3FF0, 32'hDEADBEEF);
        load(14'h3FFF, 32'hAAAA5555);

        do_start();
        fetch("f0", 14'd0, 32'h11111111);
        ack();
        step(1'b1, 1'b0, 14'd0, 1'b0);
        fetch("f1", 14'd1, 32'h22222222);
        ack();
        step(1'b1, 1'b0, 14'd0, 1'b0);
        fetch("f2", 14'd2, 32'h33333333);
        chk("seq_perr", {31'd0, proto_err}, 32'd0);

        ack();
        step(1'b0, 1'b1, 14'd1, 1'b0);
        fetch("j1", 14'd1, 32'h22222222);
        ack();
        step(1'b1, 1'b1, 14'h3FF0, 1'b0);
        fetch("jr", 14'h3FF0, 32'hDEADBEEF);

        ack();
        step(1'b0, 1'b1, 14'h3FFF, 1'b0);
        fetch("top", 14'h3FFF, 32'hAAAA5555);
        ack();
        step(1'b1, 1'b0, 14'd0, 1'b0);
        fetch("wrap", 14'd0, 32'h11111111);

        nfv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (f_valid) nfv++;
        end
        chk("hold_nfv", nfv, 0);
        chk("hold_odata", odata, 32'h11111111);
        chk("hold_pc", {18'd0, pc}, 32'd0);
        chk("hold_busy", {31'd0, busy}, 32'd1);
        chk("hold_perr", {31'd0, proto_err}, 32'd0);
        ack();
        fetch_finish = 1'b1;
        tick();
        fetch_finish = 1'b0;
        chk("ff_exec_perr", {31'd0, proto_err}, 32'd1);
        step(1'b1, 1'b0, 14'd0, 1'b0);
        fetch("sticky", 14'd1, 32'h22222222);
        chk("sticky_perr", {31'd0, proto_err}, 32'd1);

        #2;
        rst = 1'b1;
        #1;
        chk_reset("rstw");
        tick();
        rst = 1'b0;
        fetch_finish = 1'b1;
        tick();
        fetch_finish = 1'b0;
        chk("ff_idle_perr", {31'd0, proto_err}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        do_start();
        fetch("keep", 14'd0, 32'h11111111);
        ack();
        step(1'b1, 1'b0, 14'd0, 1'b0);
        fetch("k1", 14'd1, 32'h22222222);
        ack();
        load(14'd0, 32'hFFFFFFFF);
        chk("we_exec_perr", {31'd0, proto_err}, 32'd1);
        step(1'b0, 1'b0, 14'd0, 1'b1);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        chk("halt_pc", {18'd0, pc}, 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 14'd5;
        prog_data = 32'h55555555;
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        tick();
        chk("startwe_busy", {31'd0, busy}, 32'd0);
        chk("startwe_perr", {31'd0, proto_err}, 32'd0);

        do_start();
        fetch("ram0", 14'd0, 32'h11111111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_server.md
# imem_server

Instruction-memory responder feeding the fetch stage: owns the program counter and a word-addressed instruction RAM. It presents the instruction word on `odata` and pulses `f_valid` to the fetch stage, then waits for `fetch_finish`. It advances the PC on `retire`, or loads it on `jump_en`. A loader fills the RAM through a write port while the core is idle.

## Interface
- `ADDR_W`, 14, PC / RAM address width (word addressed)
- `DEPTH`, 2**ADDR_W, instruction RAM depth in 32-bit words
- `RESET_PC`, 0, PC value after reset and after `halt`

- `clk` in 1: single clock; all logic on its rising edge
- `rst` in 1: reset, asynchronous and active-high
- `start` in 1: one-cycle pulse; begins fetching at the current PC (IDLE only)
- `halt` in 1: return to IDLE at the next retire/jump point
- `prog_we` in 1: loader write strobe (honoured in IDLE only)
- `prog_addr` in ADDR_W: loader write address
- `prog_data` in 32: loader write data
- `fetch_finish` in 1: one-cycle acknowledge from the fetch stage
- `retire` in 1: one-cycle pulse; current instruction done, so PC ← PC+1
- `jump_en` in 1: one-cycle pulse; PC ← `jump_addr`
- `jump_addr` in ADDR_W: jump target
- `odata` out 32: instruction word; stable from the `f_valid` cycle until the next read
- `f_valid` out 1: one-cycle pulse; `odata` valid this cycle
- `pc` out ADDR_W: address of the instruction on `odata`
- `busy` out 1: high in every state except IDLE
- `proto_err` out 1: sticky protocol-violation flag; cleared only by `rst`

## Operation
- FSM states: IDLE, ADDR, DATA, WAIT, EXEC.
- IDLE:
  - `prog_we` writes `prog_data` to RAM[`prog_addr`].
  - `start` without `prog_we` moves to ADDR; `start` with `prog_we` is ignored.
- ADDR: drives RAM read address = `pc`; moves to DATA.
- DATA: RAM read data registers into `odata`; `f_valid`=1 for exactly this cycle; moves to WAIT.
- WAIT: holds until `fetch_finish`, then moves to EXEC. `odata` and `pc` are held.
- EXEC, in priority order:
  1. `jump_en`: PC ← `jump_addr`, then ADDR. Jump wins over a simultaneous `retire`.
  2. `retire`: PC ← PC+1, wrapping mod 2**ADDR_W (DEPTH-1 wraps to 0), then ADDR.
  3. If `halt` is high in the same cycle as a jump or retire: the PC update still happens, then the FSM goes to IDLE instead of ADDR.
  4. `halt` alone: PC ← `RESET_PC`, then IDLE.
- `proto_err` is set by any of:
  - `fetch_finish` outside WAIT
  - `retire` or `jump_en` outside EXEC
  - `prog_we` outside IDLE; the write is also dropped
- RAM contents are not reset. The RAM is inferred as single-port synchronous-read BRAM.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `odata`=0, `f_valid`=0, `busy`=0, `proto_err`=0.
- Reset asserted mid-operation aborts immediately; an in-flight `fetch_finish` after reset sets `proto_err`.
- `start` at edge N gives `f_valid` high during cycle N+2, with `odata`=RAM[pc].
- Fetch stage latches at the `f_valid` edge and returns `fetch_finish` no earlier than the following cycle. There is no timeout.
- `retire` or `jump_en` at edge M gives the next `f_valid` at M+2.
- Loop throughput: 4 cycles per instruction plus fetch-ack and execute latencies.
- A write at edge K is readable by a fetch whose ADDR state is at edge K+1 or later.

## Structure
- Shared package `core_pkg` holds:
  - `imem_state_t` enum (IDLE, ADDR, DATA, WAIT, EXEC)
  - `INST_W`=32
  - the default `ADDR_W` and `RESET_PC`
- One sub-module `imem_ram` (single-port, write-first BRAM, parameterised `ADDR_W`/`DEPTH`). The FSM and PC stay in `imem_server`.

## Test plan
- Load RAM[0..2]={0x11111111,0x22222222,0x33333333}, `start`, then ack and `retire` each instruction → `f_valid` pulses with `odata` 0x11111111, 0x22222222, 0x33333333 and `pc` 0, 1, 2; `proto_err`=0.
- In EXEC at `pc`=1, assert `jump_en` (`jump_addr`=0x3FF0, RAM[0x3FF0]=0xDEADBEEF) together with `retire` → next `odata`=0xDEADBEEF, `pc`=0x3FF0; no fetch of `pc`=2.
- `pc`=0x3FFF then `retire` → `pc`=0, `odata`=RAM[0].
- Delay `fetch_finish` 10 cycles → `odata`/`pc` held, no second `f_valid`. Then send `fetch_finish` while in EXEC → `proto_err`=1 and stays 1 until `rst`.
- Assert `rst` during WAIT → all outputs at reset values the same cycle; RAM contents preserved (a fresh `start` returns the old RAM[0]).
- `prog_we` during EXEC to address 0 with 0xFFFFFFFF → `proto_err`=1 and RAM[0] unchanged. `halt` in EXEC → IDLE, `pc`=0, `busy`=0.
